fwd_hazard_ctrl: RTL

Parametrised forwarding and load-use hazard controller for the pipelined CPU; the next generation of the plain two-stage forwarding selector. It owns its own destination-tracking pipeline, filled from decode each cycle. It produces per-read-port bypass selects qualified by write-enable and the zero register. It inserts a one-cycle stall plus an EX bubble when a load's result is needed by the very next instruction.

---
 rtl/fwd_hazard_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select and load-use hazard controller.
// Tracks the destinations of the DEPTH instructions issued after decode
// (entry 0 = EX, entry 1 = MEM, ...). It produces a bypass select for each
// register read port. It requests a one-cycle stall, with an EX bubble,
// when the instruction in decode consumes the result of the load directly
// ahead of it.
// Optional feature: define FWD_STALL_CNT_EN to add the saturating 16-bit
// stall_count output.
module fwd_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int NPORTS   = 2,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NPORTS*ADDR_W-1:0] id_rd_addr,
  input  logic [NPORTS-1:0]        id_rd_used,
  input  logic [ADDR_W-1:0]        id_dst_addr,
  input  logic                     id_reg_wr,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic [NPORTS*SEL_W-1:0]  fwd_sel,
  output logic                     stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]              stall_count
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [SEL_W-1:0]  SEL_RF = SEL_W'(DEPTH);

  // Tracking pipeline: one {addr, wr, ld} record per producer stage.
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DEPTH-1:0]  ent_wr;
  logic [DEPTH-1:0]  ent_ld;
  logic [DEPTH-1:0]  ent_prod;

  logic use_hit;
  logic hazard;
  logic bubble;

  // An entry can forward only if it writes a real (non-zero) register.
  always_comb begin
    ent_prod = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_prod[k] = ent_wr[k] & (ent_addr[k] != ZERO_A);
    end
  end

  // Per-port select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_sel = '0;
    for (int p = 0; p < NPORTS; p++) begin
      fwd_sel[p*SEL_W +: SEL_W] = SEL_RF;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_prod[k] && (ent_addr[k] == id_rd_addr[p*ADDR_W +: ADDR_W])) begin
          fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  // A used operand matching the EX-stage destination; only consulted for loads.
  always_comb begin
    use_hit = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (id_rd_used[p] && (id_rd_addr[p*ADDR_W +: ADDR_W] == ent_addr[0])) begin
        use_hit = 1'b1;
      end
    end
  end

  // The load result exists only after MEM, so the very next reader must wait one
  // cycle. A flush removes the reader, so no stall is needed in that case.
  assign hazard = id_valid & ent_prod[0] & ent_ld[0] & use_hit;
  assign stall  = hazard & ~flush;
  assign bubble = stall | flush | ~id_valid;

  // Advance the tracking pipeline; entry 0 takes decode or a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_addr[k] <= '0;
      end
      ent_wr <= '0;
      ent_ld <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        ent_addr[k] <= ent_addr[k-1];
        ent_wr[k]   <= ent_wr[k-1];
        ent_ld[k]   <= ent_ld[k-1];
      end
      ent_addr[0] <= bubble ? '0 : id_dst_addr;
      ent_wr[0]   <= bubble ? 1'b0 : id_reg_wr;
      ent_ld[0]   <= bubble ? 1'b0 : id_is_load;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Count stall cycles and saturate at all-ones; only reset clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
